// File: rtl/mulbuf.sv
// rtl/mulbuf.sv - iterative RV32M multiply/divide unit with in-order result FIFO
module mulbuf #(
    parameter int XLEN       = 32,
    parameter int MULBUF_LEN = 2,
    parameter int MULBUF_OFF = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [MULBUF_OFF-1:0] mul_this_order,
    input  logic                  mul_vld,
    input  logic [2:0]            mul_para,
    input  logic [XLEN-1:0]       mul_rs0,
    input  logic [XLEN-1:0]       mul_rs1,
    input  logic                  mul_accept,
    output logic                  mul_in_vld,
    output logic [XLEN-1:0]       mul_in_data,
    input  logic                  clear_pipeline
);

    localparam int PTR_W = (MULBUF_LEN > 1) ? $clog2(MULBUF_LEN) : 1;
    localparam logic [MULBUF_OFF-1:0] LEN_C = MULBUF_OFF'(MULBUF_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0]       a, b;
    logic [2:0]            op;
    logic [4:0]            cnt;
    logic [XLEN-1:0]       div_q, div_r, div_d;

    logic [XLEN-1:0]       fifo [MULBUF_LEN];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [MULBUF_OFF-1:0] held;

    logic                  start, push, pop;
    logic [XLEN-1:0]       push_data;
    logic [XLEN-1:0]       mul_res, div_res;

    // operand magnitudes used by the divider; only the unsigned forms (odd funct3) skip abs
    logic                  start_signed;
    logic [XLEN-1:0]       abs_rs0, abs_rs1;

    // multiplier operands sign-extended per op; MULHSU treats rs2 as unsigned
    logic                  a_sgn, b_sgn;
    logic [2*XLEN-1:0]     ext_a, ext_b, prod;

    // restoring divide step: shift one dividend bit into the partial remainder and trial-subtract
    logic [XLEN:0]         div_sh, div_diff;

    // sign fix-up for the finished divide
    logic                  d_signed, q_neg, r_neg;
    logic [XLEN-1:0]       q_fix, r_fix;

    assign start = (state == S_IDLE) && mul_vld && (held < LEN_C) && !clear_pipeline;
    assign pop   = mul_accept && (held != '0) && !clear_pipeline;

    assign mul_this_order = held;
    assign mul_in_vld     = (held != '0);
    assign mul_in_data    = mul_in_vld ? fifo[rd_ptr] : '0;

    // divide operand preparation at the start edge
    always_comb begin
        start_signed = !mul_para[0];
        abs_rs0 = (start_signed && mul_rs0[XLEN-1]) ? (~mul_rs0 + 1'b1) : mul_rs0;
        abs_rs1 = (start_signed && mul_rs1[XLEN-1]) ? (~mul_rs1 + 1'b1) : mul_rs1;
    end

    // single-cycle multiply on the latched operands
    always_comb begin
        a_sgn   = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
        b_sgn   = (op[1:0] == 2'b01);
        ext_a   = {{XLEN{a_sgn & a[XLEN-1]}}, a};
        ext_b   = {{XLEN{b_sgn & b[XLEN-1]}}, b};
        prod    = ext_a * ext_b;
        mul_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // one restoring-divide iteration and the final divide result with special cases
    always_comb begin
        div_sh   = {div_r, div_q[XLEN-1]};
        div_diff = div_sh - {1'b0, div_d};
        d_signed = !op[0];
        q_neg    = d_signed && (a[XLEN-1] ^ b[XLEN-1]);
        r_neg    = d_signed && a[XLEN-1];
        q_fix    = q_neg ? (~div_q + 1'b1) : div_q;
        r_fix    = r_neg ? (~div_r + 1'b1) : div_r;
        if (b == '0) begin
            div_res = op[1] ? a : '1;
        end else begin
            div_res = op[1] ? r_fix : q_fix;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and result push; a flush aborts whatever is in flight
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = mul_res;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = mul_para[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                push      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_DIV: begin
                if (cnt == 5'd31) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                push      = 1'b1;
                push_data = div_res;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clear_pipeline) begin
            state_nxt = S_IDLE;
            push      = 1'b0;
        end
    end

    // operand latch and divider datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            op    <= '0;
            cnt   <= '0;
            div_q <= '0;
            div_r <= '0;
            div_d <= '0;
        end else if (start) begin
            a     <= mul_rs0;
            b     <= mul_rs1;
            op    <= mul_para;
            cnt   <= '0;
            div_q <= abs_rs0;
            div_r <= '0;
            div_d <= abs_rs1;
        end else if (state == S_DIV && !clear_pipeline) begin
            cnt <= cnt + 5'd1;
            if (!div_diff[XLEN]) begin
                div_r <= div_diff[XLEN-1:0];
                div_q <= {div_q[XLEN-2:0], 1'b1};
            end else begin
                div_r <= div_sh[XLEN-1:0];
                div_q <= {div_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // result FIFO: pointers wrap naturally since the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            held   <= '0;
            for (int i = 0; i < MULBUF_LEN; i++) begin
                fifo[i] <= '0;
            end
        end else if (clear_pipeline) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            held   <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= push_data;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                held <= held + 1'b1;
            end else if (pop && !push) begin
                held <= held - 1'b1;
            end
        end
    end

    // popping an empty buffer is a protocol error from the memory buffer
    assert property (@(posedge clk) disable iff (rst) !(mul_accept && held == '0));

endmodule

// File: tb/tb_mulbuf.sv
// tb/tb_mulbuf.sv - directed self-checking bench for mulbuf
module tb_mulbuf;

    logic        clk;
    logic        rst;
    logic [1:0]  mul_this_order;
    logic        mul_vld;
    logic [2:0]  mul_para;
    logic [31:0] mul_rs0;
    logic [31:0] mul_rs1;
    logic        mul_accept;
    logic        mul_in_vld;
    logic [31:0] mul_in_data;
    logic        clear_pipeline;

    int total;
    int bad;

    mulbuf #(.XLEN(32), .MULBUF_LEN(2), .MULBUF_OFF(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .mul_this_order (mul_this_order),
        .mul_vld        (mul_vld),
        .mul_para       (mul_para),
        .mul_rs0        (mul_rs0),
        .mul_rs1        (mul_rs1),
        .mul_accept     (mul_accept),
        .mul_in_vld     (mul_in_vld),
        .mul_in_data    (mul_in_data),
        .clear_pipeline (clear_pipeline)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start one op from an empty buffer, check latency and value, then retire it
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        mul_para = op;
        mul_rs0  = a;
        mul_rs1  = b;
        mul_vld  = 1'b1;
        tick();
        mul_vld  = 1'b0;
        mul_rs0  = 32'h5A5A5A5A;
        mul_rs1  = 32'hA5A5A5A5;
        mul_para = 3'b000;
        if (op[2]) begin
            repeat (32) tick();
        end
        check({tag, "_early"}, {31'd0, mul_in_vld}, 32'd0);
        tick();
        check({tag, "_vld"}, {31'd0, mul_in_vld}, 32'd1);
        check({tag, "_data"}, mul_in_data, exp);
        mul_accept = 1'b1;
        tick();
        mul_accept = 1'b0;
        check({tag, "_popvld"}, {31'd0, mul_in_vld}, 32'd0);
        check({tag, "_order"}, {30'd0, mul_this_order}, 32'd0);
    endtask

    // push one MUL result and leave it held
    task automatic load_one(input logic [31:0] a, input logic [31:0] b);
        mul_para = 3'b000;
        mul_rs0  = a;
        mul_rs1  = b;
        mul_vld  = 1'b1;
        tick();
        mul_vld  = 1'b0;
        tick();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        mul_vld        = 1'b0;
        mul_para       = 3'b000;
        mul_rs0        = '0;
        mul_rs1        = '0;
        mul_accept     = 1'b0;
        clear_pipeline = 1'b0;
        tick();
        tick();
        check("rst_vld", {31'd0, mul_in_vld}, 32'd0);
        check("rst_data", mul_in_data, 32'd0);
        check("rst_order", {30'd0, mul_this_order}, 32'd0);
        rst = 1'b0;
        tick();

        run_op("mul",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
        run_op("mulh",   3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_op("mulhsu", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("mulhu",  3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        run_op("divu0",  3'b101, 32'h00000007, 32'h00000000, 32'hFFFFFFFF);
        run_op("remu0",  3'b111, 32'h00000007, 32'h00000000, 32'h00000007);
        run_op("divov",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_op("remov",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2);

        // back-to-back fill, third request blocked until an accept, order kept across wrap
        mul_para = 3'b000;
        mul_rs0  = 32'd2;
        mul_rs1  = 32'd3;
        mul_vld  = 1'b1;
        tick();
        mul_rs0  = 32'd4;
        mul_rs1  = 32'd5;
        tick();
        check("b2b_order1", {30'd0, mul_this_order}, 32'd1);
        tick();
        mul_rs0  = 32'd6;
        mul_rs1  = 32'd7;
        tick();
        check("b2b_full", {30'd0, mul_this_order}, 32'd2);
        tick();
        tick();
        check("b2b_blocked", {30'd0, mul_this_order}, 32'd2);
        check("b2b_head0", mul_in_data, 32'd6);
        mul_accept = 1'b1;
        tick();
        mul_accept = 1'b0;
        check("b2b_pop_order", {30'd0, mul_this_order}, 32'd1);
        check("b2b_head1", mul_in_data, 32'd20);
        tick();
        mul_vld = 1'b0;
        check("b2b_started", {30'd0, mul_this_order}, 32'd1);
        tick();
        check("b2b_third_push", {30'd0, mul_this_order}, 32'd2);
        mul_accept = 1'b1;
        tick();
        check("b2b_wrap_head", mul_in_data, 32'd42);
        tick();
        mul_accept = 1'b0;
        check("b2b_empty", {30'd0, mul_this_order}, 32'd0);

        // accept and push in the same cycle with one result held
        load_one(32'd3, 32'd5);
        mul_para = 3'b000;
        mul_rs0  = 32'd3;
        mul_rs1  = 32'd3;
        mul_vld  = 1'b1;
        tick();
        mul_vld    = 1'b0;
        mul_accept = 1'b1;
        tick();
        mul_accept = 1'b0;
        check("pp_order", {30'd0, mul_this_order}, 32'd1);
        check("pp_head", mul_in_data, 32'd9);
        mul_accept = 1'b1;
        tick();
        mul_accept = 1'b0;

        // flush during a divide with one result held
        load_one(32'd3, 32'd5);
        mul_para = 3'b100;
        mul_rs0  = 32'd100;
        mul_rs1  = 32'd7;
        mul_vld  = 1'b1;
        tick();
        mul_vld = 1'b0;
        repeat (9) tick();
        clear_pipeline = 1'b1;
        tick();
        clear_pipeline = 1'b0;
        check("clr_order", {30'd0, mul_this_order}, 32'd0);
        check("clr_vld", {31'd0, mul_in_vld}, 32'd0);
        check("clr_data", mul_in_data, 32'd0);
        repeat (30) tick();
        check("clr_nolate", {31'd0, mul_in_vld}, 32'd0);
        run_op("clr_after", 3'b000, 32'd11, 32'd13, 32'd143);

        // asynchronous reset in the middle of a divide
        load_one(32'd3, 32'd5);
        mul_para = 3'b100;
        mul_rs0  = 32'd100;
        mul_rs1  = 32'd7;
        mul_vld  = 1'b1;
        tick();
        mul_vld = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_vld", {31'd0, mul_in_vld}, 32'd0);
        check("arst_order", {30'd0, mul_this_order}, 32'd0);
        #2 rst = 1'b0;
        tick();
        repeat (40) tick();
        check("arst_nolate", {31'd0, mul_in_vld}, 32'd0);
        run_op("arst_after", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
